lfsr_rand_arbiter: RTL and testbench

//  Shares one N-bit LFSR random source among NREQ requesters. Round-robin arbitration,
//  one fresh value per grant, runtime reseed, sticky all-zero lockup detection.

---
 rtl/lfsr_rand_arbiter_if.sv | 28 ++
 rtl/lfsr_rand_arbiter.sv | 114 +++++++++++
 tb/tb_lfsr_rand_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_rand_arbiter_if.sv
// Request/grant and random-value bus for lfsr_rand_arbiter.
// master = requester side, slave = arbiter side.
interface lfsr_rand_arbiter_if #(
   parameter int unsigned N    = 13,
   parameter int unsigned NREQ = 4
);
   localparam int unsigned IDW = $clog2(NREQ);

   logic [NREQ-1:0] req;
   logic            seed_load;
   logic [N-1:0]    seed_val;
   logic [NREQ-1:0] grant;
   logic            rnd_valid;
   logic [N-1:0]    rnd_out;
   logic [IDW-1:0]  rnd_id;
   logic            busy;
   logic            lockup_err;

   modport master (
      output req, seed_load, seed_val,
      input  grant, rnd_valid, rnd_out, rnd_id, busy, lockup_err
   );

   modport slave (
      input  req, seed_load, seed_val,
      output grant, rnd_valid, rnd_out, rnd_id, busy, lockup_err
   );
endinterface

// File: rtl/lfsr_rand_arbiter.sv
// Round-robin sharing of one N-bit LFSR among NREQ requesters, with reseed and lockup flag.
// Optional LFSR_FREE_RUN_EN: LFSR steps every edge except reseed, not only on grants.
module lfsr_rand_arbiter #(
   parameter int unsigned N    = 13,
   parameter int unsigned NREQ = 4
) (
   input logic                clk,
   input logic                rst,
   lfsr_rand_arbiter_if.slave bus
);
   localparam int unsigned IDW = $clog2(NREQ);

   typedef enum logic [1:0] {IDLE, SERVE, RELOAD} state_t;

   state_t          state, state_nxt;
   logic [N-1:0]    lfsr, lfsr_nxt;
   logic [N-1:0]    rnd_out, rnd_out_nxt;
   logic [IDW-1:0]  rnd_id, rnd_id_nxt;
   logic [IDW-1:0]  ptr, ptr_nxt;
   logic [NREQ-1:0] grant, grant_nxt;
   logic            rnd_valid, rnd_valid_nxt;
   logic            busy, busy_nxt;
   logic            lockup_err, lockup_err_nxt;

   logic [NREQ-1:0] masked;
   logic [IDW-1:0]  idx;
   logic [IDW-1:0]  win;
   logic            found;

   function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] v);
      return {v[N-2:0], v[N-1] ^ v[N-2]};
   endfunction

   // Round-robin search starting just above the last winner; this cycle's grantee is excluded.
   always_comb begin
      masked = bus.req & ~grant;
      found  = 1'b0;
      win    = '0;
      idx    = '0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         idx = IDW'((32'(ptr) + i) % NREQ);
         if (!found && masked[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   // Next state and next registered outputs; every state follows the same priority rules.
   always_comb begin
      state_nxt      = IDLE;
      grant_nxt      = '0;
      rnd_valid_nxt  = 1'b0;
      busy_nxt       = 1'b0;
      rnd_out_nxt    = rnd_out;
      rnd_id_nxt     = rnd_id;
      ptr_nxt        = ptr;
      lockup_err_nxt = lockup_err;
`ifdef LFSR_FREE_RUN_EN
      lfsr_nxt       = lfsr_step(lfsr);
`else
      lfsr_nxt       = lfsr;
`endif
      if (bus.seed_load) begin
         state_nxt = RELOAD;
         busy_nxt  = 1'b1;
         if (bus.seed_val == '0) begin
            lfsr_nxt       = '1;
            lockup_err_nxt = 1'b1;
         end else begin
            lfsr_nxt = bus.seed_val;
         end
      end else if (found) begin
         state_nxt     = SERVE;
         grant_nxt     = NREQ'(1) << win;
         rnd_valid_nxt = 1'b1;
         rnd_id_nxt    = win;
         rnd_out_nxt   = lfsr;
         lfsr_nxt      = lfsr_step(lfsr);
         ptr_nxt       = win;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         lfsr       <= '1;
         grant      <= '0;
         rnd_valid  <= 1'b0;
         rnd_out    <= '0;
         rnd_id     <= '0;
         busy       <= 1'b0;
         lockup_err <= 1'b0;
         ptr        <= IDW'(NREQ - 1);
      end else begin
         state      <= state_nxt;
         lfsr       <= lfsr_nxt;
         grant      <= grant_nxt;
         rnd_valid  <= rnd_valid_nxt;
         rnd_out    <= rnd_out_nxt;
         rnd_id     <= rnd_id_nxt;
         busy       <= busy_nxt;
         lockup_err <= lockup_err_nxt;
         ptr        <= ptr_nxt;
      end
   end

   assign bus.grant      = grant;
   assign bus.rnd_valid  = rnd_valid;
   assign bus.rnd_out    = rnd_out;
   assign bus.rnd_id     = rnd_id;
   assign bus.busy       = busy;
   assign bus.lockup_err = lockup_err;
endmodule

// File: tb/tb_lfsr_rand_arbiter.sv
// Self-checking bench for lfsr_rand_arbiter: directed cases plus randomized traffic
// compared cycle by cycle against a behavioural model.
module tb_lfsr_rand_arbiter;
   localparam int unsigned N    = 13;
   localparam int unsigned NREQ = 4;
   localparam int          MASK = (1 << N) - 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lfsr_rand_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();
   lfsr_rand_arbiter #(.N(N), .NREQ(NREQ)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   int m_lfsr, m_ptr, m_gidx, m_rnd_out, m_rnd_id, m_busy, m_lock;

   function automatic int next_val(input int x);
      int fb;
      fb = ((x >> (N - 1)) ^ (x >> (N - 2))) & 1;
      return ((x << 1) | fb) & MASK;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      int prev, w, cand;
      if (rst) begin
         m_lfsr = MASK; m_ptr = NREQ - 1; m_gidx = -1;
         m_rnd_out = 0; m_rnd_id = 0; m_busy = 0; m_lock = 0;
      end else begin
         prev   = m_gidx;
         m_gidx = -1;
         m_busy = 0;
         if (bus.seed_load) begin
            m_busy = 1;
            if (int'(bus.seed_val) == 0) begin
               m_lfsr = MASK;
               m_lock = 1;
            end else begin
               m_lfsr = int'(bus.seed_val);
            end
         end else begin
            w = -1;
            for (int k = 1; k <= NREQ; k++) begin
               cand = (m_ptr + k) % NREQ;
               if (w < 0 && bus.req[cand] && cand != prev) w = cand;
            end
            if (w >= 0) begin
               m_gidx = w; m_ptr = w; m_rnd_id = w;
               m_rnd_out = m_lfsr;
               m_lfsr = next_val(m_lfsr);
            end else begin
`ifdef LFSR_FREE_RUN_EN
               m_lfsr = next_val(m_lfsr);
`endif
            end
         end
      end
   endtask

   task automatic check_all();
      chk("grant", 32'(bus.grant), (m_gidx >= 0) ? (1 << m_gidx) : 0);
      chk("rnd_valid", 32'(bus.rnd_valid), 32'(m_gidx >= 0));
      chk("rnd_id", 32'(bus.rnd_id), m_rnd_id);
      chk("rnd_out", 32'(bus.rnd_out), m_rnd_out);
      chk("busy", 32'(bus.busy), m_busy);
      chk("lockup_err", 32'(bus.lockup_err), m_lock);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   initial begin
      int g_exp[5];
      int r_exp[5];
      int grants;
      int cyc;
      g_exp = '{1, 2, 4, 8, 1};
      r_exp = '{'h1FFF, 'h1FFE, 'h1FFC, 'h1FF8, 'h1FF0};

      bus.req = '0; bus.seed_load = 1'b0; bus.seed_val = '0; rst = 1'b1;
      tick();
      chk("rst_grant", 32'(bus.grant), 0);
      chk("rst_lock", 32'(bus.lockup_err), 0);

      // Single request then re-request
      rst = 1'b0; bus.req = 4'b0001;
      tick();
      chk("t1_grant", 32'(bus.grant), 1);
      chk("t1_id", 32'(bus.rnd_id), 0);
      chk("t1_rnd", 32'(bus.rnd_out), 'h1FFF);
      tick();
      chk("t1_masked_valid", 32'(bus.rnd_valid), 0);
      tick();
`ifdef LFSR_FREE_RUN_EN
      chk("t1_rnd2", 32'(bus.rnd_out), 'h1FFC);
`else
      chk("t1_rnd2", 32'(bus.rnd_out), 'h1FFE);
`endif
      bus.req = '0;

      // All requesting: full rotation
      rst = 1'b1; tick(); rst = 1'b0;
      bus.req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t2_grant", 32'(bus.grant), g_exp[i]);
         chk("t2_rnd", 32'(bus.rnd_out), r_exp[i]);
      end
      bus.req = '0; tick();

      // Reseed with a pending request
      rst = 1'b1; tick(); rst = 1'b0;
      bus.seed_load = 1'b1; bus.seed_val = 13'h0001; bus.req = 4'b0010;
      tick();
      chk("t3_busy", 32'(bus.busy), 1);
      chk("t3_grant0", 32'(bus.grant), 0);
      bus.seed_load = 1'b0;
      tick();
      chk("t3_grant", 32'(bus.grant), 2);
      chk("t3_rnd", 32'(bus.rnd_out), 1);
      bus.req = 4'b0001;
      tick();
      chk("t3_rnd2", 32'(bus.rnd_out), 2);
      bus.req = '0; tick();

      // Zero seed: lockup flag, sticky across grants and reseeds
      bus.seed_load = 1'b1; bus.seed_val = '0;
      tick();
      chk("t4_lock", 32'(bus.lockup_err), 1);
      bus.seed_load = 1'b0; bus.req = 4'b0001;
      tick();
      chk("t4_rnd", 32'(bus.rnd_out), 'h1FFF);
      grants = 0; cyc = 0;
      while (grants < 100 && cyc < 1000) begin
         bus.req = NREQ'($urandom);
         bus.seed_load = ($urandom_range(0, 9) == 0);
         bus.seed_val = N'($urandom);
         tick();
         if (bus.grant != '0) grants++;
         chk("t4_lock_sticky", 32'(bus.lockup_err), 1);
         cyc++;
      end
      bus.seed_load = 1'b0;
      chk("t4_grant_count", 32'(grants >= 100), 1);

      // Reset while serving
      bus.req = 4'b1111;
      rst = 1'b1; tick(); rst = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      chk("t5_grant", 32'(bus.grant), 0);
      chk("t5_valid", 32'(bus.rnd_valid), 0);
      chk("t5_rnd", 32'(bus.rnd_out), 0);
      chk("t5_id", 32'(bus.rnd_id), 0);
      chk("t5_lock", 32'(bus.lockup_err), 0);
      rst = 1'b0;
      tick();
      chk("t5_grant2", 32'(bus.grant), 1);
      chk("t5_rnd2", 32'(bus.rnd_out), 'h1FFF);
      bus.req = '0;

      // Idle cycles before first request
      rst = 1'b1; tick(); rst = 1'b0;
      tick(); tick(); tick();
      bus.req = 4'b0001;
      tick();
`ifdef LFSR_FREE_RUN_EN
      chk("t6_rnd", 32'(bus.rnd_out), 'h1FF8);
`else
      chk("t6_rnd", 32'(bus.rnd_out), 'h1FFF);
`endif
      bus.req = '0;

      // Random traffic with occasional reseeds and resets
      for (int i = 0; i < 400; i++) begin
         bus.req = NREQ'($urandom);
         bus.seed_load = ($urandom_range(0, 7) == 0);
         bus.seed_val = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
         rst = ($urandom_range(0, 63) == 0);
         tick();
      end
      rst = 1'b0; bus.seed_load = 1'b0; bus.req = '0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
